set_assoc_rd_cache: RTL and testbench

//  Parametrised N-way set-associative, read-only, blocking cache between a core fetch/load port and backing memory.
//  - Successor to the fixed-geometry cache: configurable sets, ways, line length and word width.
//  - Adds true-LRU replacement, multi-beat line refill over a ready/valid memory port, and a single-cycle flush.

---
 rtl/cache_pkg.sv | 44 ++++
 rtl/cache_lru.sv | 38 +++
 rtl/set_assoc_rd_cache.sv | 220 ++++++++++++++++++++++
 tb/tb_set_assoc_rd_cache.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative read cache.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_DATA,
        RESP
    } cache_state_e;

    localparam int TAG_MAX = 64;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
    } tag_entry_t;

    function automatic int off_w(input int word_wid);
        return $clog2(word_wid / 8);
    endfunction

    function automatic int woff_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_wid, input int word_wid,
                                 input int line_words, input int sets);
        return addr_wid - off_w(word_wid) - woff_w(line_words) - idx_w(sets);
    endfunction

    function automatic tag_entry_t mk_entry(input logic v,
                                            input logic [TAG_MAX-1:0] t);
        tag_entry_t e;
        e.valid = v;
        e.tag   = t;
        return e;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Age-matrix true-LRU tracker for one set; resets to way order 0..WAYS-1.
module cache_lru #(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             touch_en_i,
    input  logic [WAY_W-1:0] touch_way_i,
    output logic [WAY_W-1:0] lru_way_o
);

    // older_q[i][j] set means way i was used less recently than way j
    logic [WAYS-1:0] older_q [WAYS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WAYS; i++)
                for (int j = 0; j < WAYS; j++)
                    older_q[i][j] <= (i < j);
        end else if (touch_en_i) begin
            for (int i = 0; i < WAYS; i++)
                for (int j = 0; j < WAYS; j++)
                    if (i == int'(touch_way_i))
                        older_q[i][j] <= 1'b0;
                    else if (j == int'(touch_way_i))
                        older_q[i][j] <= 1'b1;
        end
    end

    always_comb begin
        lru_way_o = '0;
        for (int i = 0; i < WAYS; i++)
            if (&(older_q[i] | (WAYS'(1) << i)))
                lru_way_o = WAY_W'(i);
    end

endmodule

// File: rtl/set_assoc_rd_cache.sv
// N-way set-associative blocking read cache with true-LRU and line refill.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module set_assoc_rd_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WID   = 32,
    parameter int WORD_WID   = 64,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 8,
    parameter int WAYS       = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_WID-1:0] req_addr_i,
    output logic                resp_valid_o,
    output logic [WORD_WID-1:0] resp_data_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_WID-1:0] mem_req_addr_o,
    input  logic                mem_rvalid_i,
    input  logic [WORD_WID-1:0] mem_rdata_i,
    output logic                busy_o
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
`endif
);

    localparam int OFF_W  = off_w(WORD_WID);
    localparam int WOFF_W = woff_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_WID, WORD_WID, LINE_WORDS, SETS);
    localparam int WAY_W  = $clog2(WAYS);

    cache_state_e state_q, state_d;

    logic [TAG_W-1:0]    tag_q;
    logic [IDX_W-1:0]    idx_q;
    logic [WOFF_W-1:0]   woff_q;
    logic [WAY_W-1:0]    victim_q;
    logic [WOFF_W-1:0]   cnt_q;
    logic [WORD_WID-1:0] beat_q;
    logic [WAYS-1:0]     valid_q [SETS];

    logic [TAG_W-1:0]    tag_mem  [SETS][WAYS];
    logic [WORD_WID-1:0] data_mem [SETS][WAYS][LINE_WORDS];

    logic [WAY_W-1:0]    lru_way [SETS];
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WORD_WID-1:0] hit_word;
    logic [WAY_W-1:0]    victim;
    logic                touch;
    logic [WAY_W-1:0]    touch_way;
    logic                last_beat;
    logic                unused_bits;

    assign unused_bits = ^req_addr_i[OFF_W-1:0];
    assign last_beat   = mem_rvalid_i && (&cnt_q);
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mk_entry(valid_q[idx_q][w], TAG_MAX'(tag_mem[idx_q][w])) ==
                mk_entry(1'b1, TAG_MAX'(tag_q))) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(w);
                hit_word = data_mem[idx_q][w][woff_q];
            end
        end
    end

    // Lowest-index invalid way wins over the LRU way.
    always_comb begin
        victim = lru_way[idx_q];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[idx_q][w])
                victim = WAY_W'(w);
    end

    for (genvar s = 0; s < SETS; s++) begin : g_lru
        cache_lru #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .touch_en_i (touch && (idx_q == IDX_W'(s))),
            .touch_way_i(touch_way),
            .lru_way_o  (lru_way[s])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        req_ready_o     = 1'b0;
        resp_valid_o    = 1'b0;
        resp_data_o     = '0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        touch           = 1'b0;
        touch_way       = '0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = rst_ni && !flush_i;
                if (!flush_i && req_valid_i)
                    state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid_o = 1'b1;
                    resp_data_o  = hit_word;
                    touch        = 1'b1;
                    touch_way    = hit_way;
                    state_d      = IDLE;
                end else begin
                    state_d = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {tag_q, idx_q, {(OFF_W + WOFF_W){1'b0}}};
                if (mem_req_ready_i)
                    state_d = REFILL_DATA;
            end
            REFILL_DATA: begin
                if (last_beat) begin
                    touch     = 1'b1;
                    touch_way = victim_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_data_o  = beat_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q    <= '0;
            idx_q    <= '0;
            woff_q   <= '0;
            victim_q <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            for (int s = 0; s < SETS; s++)
                valid_q[s] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        for (int s = 0; s < SETS; s++)
                            valid_q[s] <= '0;
                    end else if (req_valid_i) begin
                        woff_q <= req_addr_i[OFF_W +: WOFF_W];
                        idx_q  <= req_addr_i[OFF_W + WOFF_W +: IDX_W];
                        tag_q  <= req_addr_i[ADDR_WID-1 -: TAG_W];
                    end
                end
                LOOKUP:     victim_q <= victim;
                REFILL_REQ: cnt_q    <= '0;
                REFILL_DATA: begin
                    if (mem_rvalid_i) begin
                        cnt_q <= cnt_q + WOFF_W'(1);
                        if (cnt_q == woff_q)
                            beat_q <= mem_rdata_i;
                        if (last_beat)
                            valid_q[idx_q][victim_q] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset so they map onto distributed RAM.
    always_ff @(posedge clk_i) begin
        if (state_q == REFILL_DATA && mem_rvalid_i) begin
            data_mem[idx_q][victim_q][cnt_q] <= mem_rdata_i;
            if (&cnt_q)
                tag_mem[idx_q][victim_q] <= tag_q;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) begin
                if (!(&hit_cnt_q))
                    hit_cnt_q <= hit_cnt_q + 32'd1;
            end else if (!(&miss_cnt_q)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_set_assoc_rd_cache.sv
// Scoreboard bench for set_assoc_rd_cache at default geometry.
module tb_set_assoc_rd_cache;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        resp_valid_o;
    logic [63:0] resp_data_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        busy_o;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    set_assoc_rd_cache dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o (mem_req_addr_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_resp = 0;
    logic [63:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] line,
                                             input int b);
        return {line, 32'hDA7A_0000 + 32'(b)};
    endfunction

    function automatic logic [63:0] exp_word(input logic [31:0] a);
        return mem_word({a[31:5], 5'b0}, int'(a[4:3]));
    endfunction

    always @(negedge clk_i) begin
        if (rst_ni && resp_valid_o) begin
            n_resp++;
            if (sb_q.size() == 0) chk("resp_unexpected", resp_valid_o, 0);
            else chk("resp_data", resp_data_o, sb_q.pop_front());
        end
    end

    task automatic issue(input logic [31:0] a);
        int t;
        @(negedge clk_i);
        t = 0;
        while (!req_ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("req_ready", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        sb_q.push_back(exp_word(a));
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic read_hit(input logic [31:0] a);
        issue(a);
        chk("hit_resp_valid", resp_valid_o, 1);
        chk("hit_no_memreq", mem_req_valid_o, 0);
    endtask

    task automatic read_miss(input logic [31:0] a, input int beats);
        int t;
        logic [31:0] line;
        line = {a[31:5], 5'b0};
        issue(a);
        chk("miss_no_resp", resp_valid_o, 0);
        t = 0;
        while (!mem_req_valid_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("memreq_valid", mem_req_valid_o, 1);
        chk("memreq_addr", mem_req_addr_o, line);
        @(negedge clk_i);
        chk("memreq_hold", {mem_req_valid_o, mem_req_addr_o}, {1'b1, line});
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < beats; b++) begin
            if ($urandom_range(1, 0) == 1) begin
                mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
                @(negedge clk_i);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(line, b);
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
        end
        if (beats == 4) begin
            chk("miss_resp_valid", resp_valid_o, 1);
            @(negedge clk_i);
            chk("idle_after_resp", busy_o, 0);
        end
    endtask

    task automatic flush_pulse(input bit with_req, input logic [31:0] a);
        @(negedge clk_i);
        flush_i     = 1'b1;
        req_valid_i = with_req;
        req_addr_i  = a;
        #1;
        chk("flush_ready_low", req_ready_o, 0);
        @(negedge clk_i);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        chk("flush_req_ignored", busy_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        req_valid_i     = 1'b0;
        req_addr_i      = '0;
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = '0;
        #12;
        chk("rst_outputs", {req_ready_o, resp_valid_o, mem_req_valid_o,
                            busy_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", req_ready_o, 1);

        // cold miss then hit in the same line
        read_miss(32'h0000_0108, 4);
        read_hit(32'h0000_0110);

`ifdef CACHE_STATS_EN
        chk("hit_cnt", hit_cnt_o, 1);
        chk("miss_cnt", miss_cnt_o, 1);
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk_i);
        release dut.hit_cnt_q;
        read_hit(32'h0000_0110);
        @(negedge clk_i);
        chk("hit_cnt_sat", hit_cnt_o, 32'hFFFF_FFFF);
`endif

        // flush with a pending request, then the line must miss
        flush_pulse(1'b1, 32'h0000_0110);
        read_miss(32'h0000_0110, 4);

        // LRU victim selection in set 0
        flush_pulse(1'b0, 32'h0);
        read_miss(32'h0000_1000, 4);
        read_miss(32'h0000_1100, 4);
        read_miss(32'h0000_1208, 4);
        read_miss(32'h0000_1318, 4);
        read_hit(32'h0000_1008);
        read_miss(32'h0000_1410, 4);
        read_hit(32'h0000_1018);
        read_hit(32'h0000_1300);
        read_miss(32'h0000_1108, 4);

        // reset in the middle of a refill
        read_miss(32'h0000_2048, 2);
        rst_ni = 1'b0;
        #1;
        chk("abort_outputs", {req_ready_o, resp_valid_o, mem_req_valid_o,
                              busy_o, resp_data_o}, 0);
        sb_q.delete();
        @(negedge clk_i);
        rst_ni       = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        chk("stray_beat_idle", {busy_o, resp_valid_o}, 0);
        read_miss(32'h0000_2048, 4);

        @(negedge clk_i);
        chk("sb_drained", 64'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
